// File: rtl/fma_cpa_pipe_pkg.sv
// Shared FMA datapath sizing: operand width from significand width, LZC width, default split.
// Pure definitions; no logic, no latency, no flow control.
// Imported by the CPA pipe and the sign-bit counter.
package fma_cpa_pipe_pkg;

    localparam int SIG_WIDTH_DEF = 23;
    localparam int TAG_W_DEF     = 4;
    localparam int SPLIT_DEF     = 26;

    // Redundant product width: two (SIG_WIDTH+1)-bit significands plus guard/sign bits.
    function automatic int fma_w(input int sig_width);
        return 2 * (sig_width + 1) + 3;
    endfunction

    localparam int W_DEF     = fma_w(SIG_WIDTH_DEF);
    localparam int LZC_W_DEF = $clog2(W_DEF);

endpackage

// File: rtl/fma_sign_lzc.sv
// Redundant-sign-bit counter: bits below the MSB that equal the MSB, stopping at the first mismatch.
// Latency: combinational.
// Backpressure: none; pure function of din.
module fma_sign_lzc
    import fma_cpa_pipe_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LZC_W = LZC_W_DEF
) (
    input  logic [W-1:0]     din,
    output logic [LZC_W-1:0] cnt
);

    logic stop;

    always_comb begin
        cnt  = '0;
        stop = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            if (!stop && (din[i] == din[W-1])) begin
                cnt = cnt + LZC_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fma_cpa_pipe.sv
// Resolves the compressor's redundant sum/carry into a binary product plus redundant-sign-bit count.
// Latency: 2 cycles (low SPLIT bits in stage 1, high bits and count in stage 2).
// Backpressure: valid/ready per stage, no skid; full throughput, output held while stalled.
module fma_cpa_pipe
    import fma_cpa_pipe_pkg::*;
#(
    parameter int  SIG_WIDTH = SIG_WIDTH_DEF,
    parameter int  SPLIT     = SPLIT_DEF,
    parameter int  TAG_W     = TAG_W_DEF,
    localparam int W         = fma_w(SIG_WIDTH),
    localparam int LZC_W     = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [LZC_W-1:0] out_lzc,
    output logic [TAG_W-1:0] out_tag
);

    localparam int HW = W - SPLIT;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c_lo;
    logic [HW-1:0]    s1_sum_hi;
    logic [HW-1:0]    s1_carry_hi;
    logic [TAG_W-1:0] s1_tag;

    logic [W-1:0]     r_result;
    logic [LZC_W-1:0] r_lzc;
    logic [TAG_W-1:0] r_tag;

    logic             s2_ready;
    logic             s1_fire;
    logic             s2_fire;
    logic [SPLIT:0]   lo_full;
    logic [HW-1:0]    hi;
    logic [W-1:0]     s2_result;
    logic [LZC_W-1:0] s2_lzc;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign s1_fire  = in_valid && in_ready;
    assign s2_fire  = s1_valid && s2_ready;

    assign lo_full   = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
    assign hi        = s1_sum_hi + s1_carry_hi + HW'(s1_c_lo);
    assign s2_result = {hi, s1_lo};

    fma_sign_lzc #(
        .W     (W),
        .LZC_W (LZC_W)
    ) u_sign_lzc (
        .din (s2_result),
        .cnt (s2_lzc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_lo       <= '0;
            s1_c_lo     <= 1'b0;
            s1_sum_hi   <= '0;
            s1_carry_hi <= '0;
            s1_tag      <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_fire) begin
                s1_valid <= 1'b0;
            end
            if (s1_fire && !flush) begin
                s1_lo       <= lo_full[SPLIT-1:0];
                s1_c_lo     <= lo_full[SPLIT];
                s1_sum_hi   <= in_sum[W-1:SPLIT];
                s1_carry_hi <= in_carry[W-1:SPLIT];
                s1_tag      <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r_result  <= '0;
            r_lzc     <= '0;
            r_tag     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_fire) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_fire && !flush) begin
                r_result <= s2_result;
                r_lzc    <= s2_lzc;
                r_tag    <= s1_tag;
            end
        end
    end

    // Stale data after a flush stays hidden behind out_valid.
    assign out_result = out_valid ? r_result : '0;
    assign out_lzc    = out_valid ? r_lzc    : '0;
    assign out_tag    = out_valid ? r_tag    : '0;

endmodule

// File: tb/tb_fma_cpa_pipe.sv
// Directed-vector bench for fma_cpa_pipe at default parameters (W=51, SPLIT=26, TAG_W=4).
module tb_fma_cpa_pipe;

    localparam int W  = 51;
    localparam int LW = 6;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sum;
    logic [W-1:0]  in_carry;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [LW-1:0] out_lzc;
    logic [TW-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    fma_cpa_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_lzc    (out_lzc),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one op, returns out_valid one cycle later and the outputs two cycles later.
    task automatic do_op(input logic [W-1:0] s, input logic [W-1:0] c, input logic [TW-1:0] t,
                         output logic v_early, output logic v_late, output logic [W-1:0] r,
                         output logic [LW-1:0] l, output logic [TW-1:0] tg);
        out_ready = 1'b1;
        in_sum    = s;
        in_carry  = c;
        in_tag    = t;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        v_early = out_valid;
        tick();
        v_late = out_valid;
        r      = out_result;
        l      = out_lzc;
        tg     = out_tag;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_carry = '0; in_tag = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (out_result !== '0 || out_lzc !== '0 || out_tag !== '0) begin
            errors++; $display("FAIL reset_outputs got %h/%0d/%0d want 0/0/0", out_result, out_lzc, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        logic ve, vl; logic [W-1:0] r; logic [LW-1:0] l; logic [TW-1:0] tg;
        do_op(51'd5, 51'd3, 4'd1, ve, vl, r, l, tg);
        checks++;
        if (ve !== 1'b0) begin errors++; $display("FAIL basic_latency1 out_valid got %b want 0", ve); end
        checks++;
        if (vl !== 1'b1) begin errors++; $display("FAIL basic_latency2 out_valid got %b want 1", vl); end
        checks++;
        if (r !== 51'd8 || l !== 6'd46 || tg !== 4'd1) begin
            errors++; $display("FAIL basic got %h/%0d/%0d want 8/46/1", r, l, tg);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_split_carry;
        logic ve, vl; logic [W-1:0] r; logic [LW-1:0] l; logic [TW-1:0] tg;
        do_op(51'h3FFFFFF, 51'd1, 4'd2, ve, vl, r, l, tg);
        checks++;
        if (vl !== 1'b1 || r !== 51'h4000000 || l !== 6'd23 || tg !== 4'd2) begin
            errors++; $display("FAIL split_carry got v%b %h/%0d/%0d want 1 4000000/23/2", vl, r, l, tg);
        end
    endtask

    task automatic test_extremes;
        logic ve, vl; logic [W-1:0] r; logic [LW-1:0] l; logic [TW-1:0] tg;
        do_op(51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFE, 4'd3, ve, vl, r, l, tg);
        checks++;
        if (r !== 51'h7FFFFFFFFFFFD || l !== 6'd48 || tg !== 4'd3) begin
            errors++; $display("FAIL negative got %h/%0d/%0d want 7fffffffffffd/48/3", r, l, tg);
        end
        do_op(51'd0, 51'd0, 4'd4, ve, vl, r, l, tg);
        checks++;
        if (vl !== 1'b1 || r !== 51'd0 || l !== 6'd50) begin
            errors++; $display("FAIL zero got v%b %h/%0d want 1 0/50", vl, r, l);
        end
        do_op(51'h7FFFFFFFFFFFF, 51'd0, 4'd5, ve, vl, r, l, tg);
        checks++;
        if (r !== 51'h7FFFFFFFFFFFF || l !== 6'd50) begin
            errors++; $display("FAIL all_ones got %h/%0d want 7ffffffffffff/50", r, l);
        end
        do_op(51'h2000000000000, 51'd0, 4'd6, ve, vl, r, l, tg);
        checks++;
        if (r !== 51'h2000000000000 || l !== 6'd0) begin
            errors++; $display("FAIL msb_differ got %h/%0d want 2000000000000/0", r, l);
        end
        // Carry into the top bit is dropped: 2^50 + 2^50 wraps to 0.
        do_op(51'h4000000000000, 51'h4000000000000, 4'd7, ve, vl, r, l, tg);
        checks++;
        if (r !== 51'd0 || l !== 6'd50) begin
            errors++; $display("FAIL wrap got %h/%0d want 0/50", r, l);
        end
    endtask

    task automatic test_back_to_back;
        int nt = 1;
        int got = 0;
        bit dropped = 1'b0;
        int hs[6];
        logic [W-1:0] exp_r;
        for (int c = 0; c < 40 && got < 6; c++) begin
            tick();
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (nt <= 6);
            in_sum    = W'(nt * 1000 + 7);
            in_carry  = W'(nt * 3);
            in_tag    = TW'(nt);
            #1;
            if (in_valid && !in_ready) dropped = 1'b1;
            if (out_valid && out_ready) begin
                exp_r = W'((got + 1) * 1003 + 7);
                checks++;
                if (out_result !== exp_r || out_tag !== TW'(got + 1)) begin
                    errors++;
                    $display("FAIL b2b_item%0d got %0d/%0d want %0d/%0d", got + 1, out_result, out_tag, exp_r, got + 1);
                end
                hs[got] = c;
                got++;
            end
            if (in_valid && in_ready) nt++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 6) begin errors++; $display("FAIL b2b_count got %0d want 6", got); end
        checks++;
        if (!dropped) begin errors++; $display("FAIL b2b_in_ready_drop got never-low want low"); end
        if (got == 6) begin
            checks++;
            if (hs[1] - hs[0] != 4 || hs[5] - hs[1] != 4) begin
                errors++;
                $display("FAIL b2b_throughput got gaps %0d/%0d want 4/4", hs[1] - hs[0], hs[5] - hs[1]);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_flush;
        int seen = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_sum = 51'd10; in_carry = 51'd1; in_tag = 4'd9;
        tick();
        in_tag = 4'd10;
        tick();
        in_tag = 4'd11;
        flush  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_full got in_ready %b out_valid %b want 0 1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_clear got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_leak got %0d results want 0", seen); end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_sum = 51'd100; in_carry = 51'd23; in_tag = 4'd12;
        tick();
        in_tag = 4'd13;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 51'd123) begin
            errors++; $display("FAIL rst_mid_pre got v%b %0d want 1 123", out_valid, out_result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0) begin
            errors++; $display("FAIL rst_mid_async got v%b %h want 0 0", out_valid, out_result);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_mid_leak got %0d results want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split_carry();
        test_extremes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma_cpa_pipe.md
Name: fma_cpa_pipe

Overview:
- Downstream consumer of the FMA 6:2 partial-product compressor: takes its redundant sum/carry pair (2*(SIG_WIDTH+1)+3 bits, two's complement, sign-extended) and resolves it into one binary product.
- Two-stage pipelined carry-propagate adder split at SPLIT bits.
- Also produces a redundant-sign-bit count for the downstream normalizer.
- Valid/ready handshakes on both sides; full throughput; tag passthrough for in-order tracking.

Parameters:
- SIG_WIDTH, 23, significand width excluding hidden bit; datapath width W = 2*(SIG_WIDTH+1)+3 (51 at default).
- SPLIT, 26, number of low bits added in stage 1 (1 <= SPLIT < W).
- TAG_W, 4, width of sideband tag carried with each operation.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; drops all in-flight operations.
- in_valid  input  1  sum/carry/tag valid.
- in_ready  output  1  stage accepts input this cycle.
- in_sum  input  W  compressor sum vector.
- in_carry  input  W  compressor carry vector (already left-shifted by producer).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  W  (in_sum + in_carry) mod 2^W.
- out_lzc  output  clog2(W)  count of bits from W-2 downward equal to bit W-1, stopping at first mismatch.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0. out_result, out_lzc and out_tag reset to 0. Data registers are don't-care internally but must not leak to outputs while out_valid=0.
- Stage 1 captures on in_valid && in_ready:
  - lo_sum = in_sum[SPLIT-1:0] + in_carry[SPLIT-1:0], SPLIT bits plus carry-out c_lo.
  - High halves of in_sum and in_carry, and in_tag, are registered unchanged.
- Stage 2 captures when s1_valid && s2_ready:
  - hi = sum_hi + carry_hi + c_lo, mod 2^(W-SPLIT).
  - out_result = {hi, lo_sum}.
  - out_lzc is computed from the full result; it is registered together with the result.
- Latency: 2 cycles, from the input handshake to out_valid=1, with no stall.
- Handshake:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational, no skid; one result per cycle sustained).
  - Output registers hold stable while out_valid && !out_ready.
  - s1_valid is cleared when stage 1 drains and is not refilled in the same cycle.
- Simultaneous events:
  - An accept into stage 1 and a transfer to stage 2 in the same cycle both occur; s1_valid stays 1.
  - An output handshake and a stage-2 load in the same cycle: out_valid stays 1 with the new data.
- flush=1: next edge s1_valid=0 and out_valid=0. Any input presented that cycle is discarded. in_ready is still driven by the normal equation.
- Arithmetic:
  - Final carry-out of bit W-1 is discarded; no overflow flag.
  - Producer sign extension guarantees the result fits in W bits.
- lzc boundaries:
  - Result 0 or all-ones gives out_lzc = W-1.
  - Bits W-1 and W-2 differ gives out_lzc = 0.
- Reset mid-operation: all in-flight operations are lost; no output handshake completes until new inputs arrive.

Decomposition:
- Shared FMA package holds:
  - W as a function of SIG_WIDTH;
  - LZC_W = clog2(W);
  - the default SPLIT.
- One natural sub-module: fma_sign_lzc (combinational redundant-sign-bit counter, W-bit in, LZC_W out). It is reusable by the normalizer.

Test Plan:
- Basic: in_sum=5, in_carry=3, tag=1, out_ready=1 -> 2 cycles later out_result=8, out_lzc=46, out_tag=1.
- Split carry: in_sum=2^26-1, in_carry=1 -> out_result=2^26, out_lzc=23.
- Negative and extremes:
  - in_sum=-1 (all ones), in_carry=-2 -> out_result=-3 (0x7FFFFFFFFFFFD), out_lzc=48.
  - in_sum=0, in_carry=0 -> out_lzc=50.
- Back-to-back with stall:
  - Setup: stream tags 1..6 on consecutive cycles; hold out_ready=0 for cycles 3..5.
  - Required: in_ready drops while both stages are full; all six results emerge in order with correct sums, none lost or duplicated.
  - Required: after the stall, throughput returns to 1/cycle.
- Flush and reset:
  - flush with both stages full -> next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
  - rst_n pulsed low asynchronously mid-stream -> out_valid=0 immediately, and out_result=0.
